seq_detect_param: RTL and testbench

//  Parametrised serial pattern detector. Samples a 1-bit stream on clk and pulses w for one

---
 rtl/seq_detect_param.sv | 112 +++++++++++
 tb/tb_seq_detect_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: pulses w one cycle after each PATTERN match.
// Optional saturating match counter is built when MATCH_CNT_EN is defined.
module seq_detect_param #(
  parameter int unsigned       PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter int unsigned       CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             overlap,
  input  logic             clr,
  output logic             w
`ifdef MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int unsigned HIST_W = PAT_W - 1;
  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_bad_param
    $error("seq_detect_param: PAT_W must be 2..32 and CNT_W >= 1");
  end

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                w_q, w_d;
  logic [PAT_W-1:0]    win;
  logic                hit;

`ifdef MATCH_CNT_EN
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Match window is the held history plus the bit being sampled now.
  assign win = {hist_q, a};
  assign hit = (state_q == S_ARMED) && (win == PATTERN);

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    w_d     = 1'b0;
`ifdef MATCH_CNT_EN
    cnt_d   = cnt_q;
`endif
    if (clr) begin
      state_d = S_FILL;
      hist_d  = '0;
      fill_d  = '0;
`ifdef MATCH_CNT_EN
      cnt_d   = '0;
`endif
    end else if (en) begin
      w_d = hit;
      if (hit && !overlap) begin
        // Non-overlapping: the matched bits cannot seed the next match.
        state_d = S_FILL;
        hist_d  = '0;
        fill_d  = '0;
      end else begin
        hist_d  = win[PAT_W-2:0];
        fill_d  = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
        state_d = (fill_d == FILL_MAX) ? S_ARMED : S_FILL;
      end
`ifdef MATCH_CNT_EN
      if (hit && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      hist_q  <= '0;
      fill_q  <= '0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      w_q     <= w_d;
    end
  end

  assign w = w_q;

`ifdef MATCH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus a random stream against a bit-queue model.
// Builds with or without MATCH_CNT_EN.
module tb_seq_detect_param;

  logic clk;
  logic rst, en, a, overlap, clr;
  logic w_a, w_b, w_c;
`ifdef MATCH_CNT_EN
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [1:0] cnt_c;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference state: bits received since the last clear, trimmed to what can still matter.
  bit q4[$];
  bit q2[$];
  bit exp_wa, exp_wc;
  int exp_ca, exp_cb, exp_cc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .a(a), .overlap(overlap), .clr(clr), .w(w_a)
`ifdef MATCH_CNT_EN
    , .match_cnt(cnt_a)
`endif
  );

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .a(a), .overlap(overlap), .clr(clr), .w(w_b)
`ifdef MATCH_CNT_EN
    , .match_cnt(cnt_b)
`endif
  );

  seq_detect_param #(.PAT_W(2), .PATTERN(2'b01), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(en), .a(a), .overlap(overlap), .clr(clr), .w(w_c)
`ifdef MATCH_CNT_EN
    , .match_cnt(cnt_c)
`endif
  );

  function automatic bit tail_match(input bit q[$], input int pw, input int pat);
    int v;
    v = 0;
    if (q.size() < pw) return 1'b0;
    for (int i = 0; i < pw; i++) v = (v << 1) | int'(q[q.size() - pw + i]);
    return v == pat;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q4.delete();
    q2.delete();
    exp_wa = 1'b0;
    exp_wc = 1'b0;
    exp_ca = 0;
    exp_cb = 0;
    exp_cc = 0;
  endtask

  task automatic model_step(input bit e_i, input bit a_i, input bit ov_i, input bit c_i);
    bit h4, h2;
    if (c_i) begin
      model_clear();
    end else if (e_i) begin
      q4.push_back(a_i);
      q2.push_back(a_i);
      h4 = tail_match(q4, 4, 'b1011);
      h2 = tail_match(q2, 2, 'b01);
      if (h4 && !ov_i) q4.delete();
      if (h2 && !ov_i) q2.delete();
      while (q4.size() > 3) q4.delete(0);
      while (q2.size() > 1) q2.delete(0);
      exp_wa = h4;
      exp_wc = h2;
      if (h4) begin
        exp_ca = (exp_ca < 255) ? exp_ca + 1 : 255;
        exp_cb = (exp_cb < 3) ? exp_cb + 1 : 3;
      end
      if (h2) exp_cc = (exp_cc < 3) ? exp_cc + 1 : 3;
    end else begin
      exp_wa = 1'b0;
      exp_wc = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_w4"}, 32'(w_a), 32'(exp_wa));
    chk({tag, "_w4c2"}, 32'(w_b), 32'(exp_wa));
    chk({tag, "_w2"}, 32'(w_c), 32'(exp_wc));
`ifdef MATCH_CNT_EN
    chk({tag, "_cnt8"}, 32'(cnt_a), 32'(exp_ca));
    chk({tag, "_cnt2"}, 32'(cnt_b), 32'(exp_cb));
    chk({tag, "_cntp2"}, 32'(cnt_c), 32'(exp_cc));
`endif
  endtask

  task automatic step(input string tag, input bit e_i, input bit a_i, input bit ov_i,
                      input bit c_i);
    en      = e_i;
    a       = a_i;
    overlap = ov_i;
    clr     = c_i;
    @(posedge clk);
    #1;
    model_step(e_i, a_i, ov_i, c_i);
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit s1[16];
    int pulses;
    int samples;
    bit ov_r;
    bit e_r, c_r;

    s1 = '{1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1};
    rst = 1'b1; en = 1'b0; a = 1'b0; overlap = 1'b1; clr = 1'b0;
    #50;
    model_clear();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: overlapping, 1011011 -> pulses after bits 4 and 7
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step("t1", 1'b1, s1[i], 1'b1, 1'b0);
      if (w_a === 1'b1) pulses++;
    end
    chk("t1_pulses", 32'(pulses), 32'd2);
`ifdef MATCH_CNT_EN
    chk("t1_cnt", 32'(cnt_a), 32'd2);
`endif
    do_reset("t1_rst");

    // 2: same stream, non-overlapping -> one pulse
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step("t2", 1'b1, s1[i], 1'b0, 1'b0);
      if (w_a === 1'b1) pulses++;
    end
    chk("t2_pulses", 32'(pulses), 32'd1);
`ifdef MATCH_CNT_EN
    chk("t2_cnt", 32'(cnt_a), 32'd1);
`endif
    do_reset("t2_rst");

    // 3: en gaps inside a pattern
    pulses = 0;
    step("t3", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t3", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("t3_gap", 1'b0, i[0], 1'b1, 1'b0);
      if (w_a === 1'b1) pulses++;
    end
    step("t3", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t3", 1'b1, 1'b1, 1'b1, 1'b0);
    if (w_a === 1'b1) pulses++;
    chk("t3_pulses", 32'(pulses), 32'd1);
    do_reset("t3_rst");

    // 4: clr discards a partial pattern and its own bit
    pulses = 0;
    step("t4", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t4", 1'b1, 1'b0, 1'b1, 1'b0);
    step("t4", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t4_clr", 1'b1, 1'b1, 1'b1, 1'b1);
    if (w_a === 1'b1) pulses++;
    for (int i = 0; i < 4; i++) begin
      step("t4", 1'b1, s1[i], 1'b1, 1'b0);
      if (w_a === 1'b1) pulses++;
    end
    chk("t4_pulses", 32'(pulses), 32'd1);

    // 5: async reset with w high, then mid-pattern reset losing the partial pattern
    do_reset("t5_rst_w");
    for (int i = 0; i < 4; i++) step("t5a", 1'b1, s1[i], 1'b1, 1'b0);
    do_reset("t5_rst_hi");
    step("t5b", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t5b", 1'b1, 1'b0, 1'b1, 1'b0);
    step("t5b", 1'b1, 1'b1, 1'b1, 1'b0);
    do_reset("t5_rst_mid");
    step("t5_after", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_after_w", 32'(w_a), 32'd0);
    do_reset("t5_rst_end");

    // 6: five overlapping matches; 2-bit counter sticks at 3
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step("t6", 1'b1, s1[i], 1'b1, 1'b0);
      if (w_b === 1'b1) pulses++;
    end
    chk("t6_pulses", 32'(pulses), 32'd5);
`ifdef MATCH_CNT_EN
    chk("t6_cnt2", 32'(cnt_b), 32'd3);
    chk("t6_cnt8", 32'(cnt_a), 32'd5);
`endif
    do_reset("t6_rst");

    // Random stream with en gaps, clears, overlap changes and rare resets
    samples = 0;
    ov_r = 1'b1;
    while (samples < 10000) begin
      e_r = ($urandom_range(0, 3) != 0);
      c_r = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) ov_r = ~ov_r;
      step("rnd", e_r, 1'($urandom_range(0, 1)), ov_r, c_r);
      if (e_r && !c_r) samples++;
      if ($urandom_range(0, 999) == 0) do_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
